// File: rtl/present_pkg.sv
// Shared types and widths for the present scheduler and its slots.
// Coordinate and counter widths are fixed here so slot_t stays a plain packed struct.
package present_pkg;

  localparam int X_BITS    = 11;
  localparam int Y_BITS    = 11;
  localparam int LIFE_BITS = 8;
  localparam int COOL_BITS = 5;

  typedef enum logic [1:0] {
    PT_LIFE   = 2'd0,
    PT_TIME   = 2'd1,
    PT_SHIELD = 2'd2,
    PT_NONE   = 2'd3
  } present_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    ALLOC = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic                 valid;
    logic [X_BITS-1:0]    x;
    logic [Y_BITS-1:0]    y;
    present_type_t        ptype;
    logic [LIFE_BITS-1:0] lifetime;
  } slot_t;

  // One frame of fall; the extra sum bit keeps a y near the top of the range from wrapping.
  function automatic logic [Y_BITS-1:0] fall_y(input logic [Y_BITS-1:0] y,
                                               input int step, input int floor_y);
    logic [Y_BITS:0] sum;
    sum = {1'b0, y} + (Y_BITS+1)'(step);
    if (sum > (Y_BITS+1)'(floor_y)) return Y_BITS'(floor_y);
    return sum[Y_BITS-1:0];
  endfunction

endpackage

// File: rtl/present_slot.sv
// One present slot: load, per-frame fall, floor lifetime and pickup clear.
// Pickup beats expiry beats fall; load only ever targets a slot that is currently empty.
module present_slot
  import present_pkg::*;
#(
  parameter int FLOOR_Y         = 440,
  parameter int FALL_STEP       = 2,
  parameter int LIFETIME_FRAMES = 180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              load,
  input  logic [X_BITS-1:0] load_x,
  input  logic [Y_BITS-1:0] load_y,
  input  present_type_t     load_type,
  input  logic              hit,
  output logic              valid,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output present_type_t     ptype
);

  slot_t cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= '0;
    end else if (load) begin
      cur.valid    <= 1'b1;
      cur.x        <= load_x;
      cur.y        <= load_y;
      cur.ptype    <= load_type;
      cur.lifetime <= LIFE_BITS'(LIFETIME_FRAMES);
    end else if (cur.valid) begin
      if (hit) begin
        cur.valid <= 1'b0;
      end else if (frame_start) begin
        if (cur.y < Y_BITS'(FLOOR_Y)) begin
          cur.y <= fall_y(cur.y, FALL_STEP, FLOOR_Y);
        end else begin
          cur.lifetime <= cur.lifetime - 1'b1;
          if (cur.lifetime == LIFE_BITS'(1)) cur.valid <= 1'b0;
        end
      end
    end
  end

  assign valid = cur.valid;
  assign x     = cur.x;
  assign y     = cur.y;
  assign ptype = cur.ptype;

endmodule

// File: rtl/present_scheduler.sv
// Pop-to-present scheduler: round-robin pop arbitration, random type handshake, slot allocation; 4 clocks pop to slot_valid.
// No backpressure: late pops on a pending requester or during cooldown are dropped. PRESENT_BLANK_EN makes type 3 a no-drop.
module present_scheduler
  import present_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int FLOOR_Y         = 440,
  parameter int FALL_STEP       = 2,
  parameter int LIFETIME_FRAMES = 180,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic [1:0]                  pop_req,
  input  logic [X_BITS-1:0]           pop_x0,
  input  logic [X_BITS-1:0]           pop_x1,
  input  logic [Y_BITS-1:0]           pop_y0,
  input  logic [Y_BITS-1:0]           pop_y1,
  output logic                        rand_rise,
  input  logic [1:0]                  rand_dout,
  input  logic [NUM_SLOTS-1:0]        pickup_hit,
  output logic [NUM_SLOTS-1:0]        slot_valid,
  output logic [NUM_SLOTS*X_BITS-1:0] slot_x,
  output logic [NUM_SLOTS*Y_BITS-1:0] slot_y,
  output logic [NUM_SLOTS*2-1:0]      slot_type,
  output logic                        award_valid,
  output logic [1:0]                  award_type
);

  sched_state_t         state, state_next;
  logic [1:0]           pending;
  logic [X_BITS-1:0]    pend_x [2];
  logic [Y_BITS-1:0]    pend_y [2];
  logic [X_BITS-1:0]    pop_xa [2];
  logic [Y_BITS-1:0]    pop_ya [2];
  logic                 last_grant;
  logic                 grant_vld;
  logic                 grant_sel;
  logic [X_BITS-1:0]    req_x;
  logic [Y_BITS-1:0]    req_y;
  present_type_t        req_type;
  logic [COOL_BITS-1:0] cooldown;
  logic                 blank;
  logic                 alloc_fire;
  logic                 free_found;
  logic                 hit_found;
  logic [NUM_SLOTS-1:0] load_vec;
  logic [NUM_SLOTS-1:0] hit_vec;
  present_type_t        award_sel;

  logic [X_BITS-1:0]    sx [NUM_SLOTS];
  logic [Y_BITS-1:0]    sy [NUM_SLOTS];
  present_type_t        st [NUM_SLOTS];

  assign pop_xa[0] = pop_x0;
  assign pop_xa[1] = pop_x1;
  assign pop_ya[0] = pop_y0;
  assign pop_ya[1] = pop_y1;

`ifdef PRESENT_BLANK_EN
  assign blank = (req_type == PT_NONE);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The requester granted last loses a tie; last_grant resets to 1 so requester 0 wins first.
  always_comb begin
    state_next = state;
    grant_vld  = 1'b0;
    grant_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant_vld  = 1'b1;
          grant_sel  = (pending == 2'b11) ? ~last_grant : pending[1];
          state_next = REQ;
        end
      end
      REQ:     state_next = WAIT;
      WAIT:    state_next = ALLOC;
      ALLOC:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lowest-index free slot, judged from valid at the start of the cycle.
  always_comb begin
    load_vec   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && !slot_valid[i]) begin
        load_vec[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
    if (state != ALLOC || blank) load_vec = '0;
  end

  assign alloc_fire = |load_vec;
  assign hit_vec    = pickup_hit & slot_valid;

  always_comb begin
    award_sel = PT_LIFE;
    hit_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit_found && hit_vec[i]) begin
        award_sel = st[i];
        hit_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      last_grant <= 1'b1;
      req_x      <= '0;
      req_y      <= '0;
      req_type   <= PT_LIFE;
      cooldown   <= '0;
      rand_rise  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pend_x[i] <= '0;
        pend_y[i] <= '0;
      end
    end else begin
      rand_rise <= (state_next == REQ);
      for (int i = 0; i < 2; i++) begin
        if (grant_vld && grant_sel == 1'(i)) begin
          pending[i] <= 1'b0;
        end else if (pop_req[i] && cooldown == '0 && !pending[i]) begin
          pending[i] <= 1'b1;
          pend_x[i]  <= pop_xa[i];
          pend_y[i]  <= pop_ya[i];
        end
      end
      if (grant_vld) begin
        last_grant <= grant_sel;
        req_x      <= pend_x[grant_sel];
        req_y      <= pend_y[grant_sel];
      end
      if (state == WAIT) req_type <= present_type_t'(rand_dout);
      if (alloc_fire)                          cooldown <= COOL_BITS'(COOLDOWN_FRAMES);
      else if (startOfFrame && cooldown != '0) cooldown <= cooldown - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      award_valid <= 1'b0;
      award_type  <= 2'd0;
    end else begin
      award_valid <= |hit_vec;
      award_type  <= award_sel;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    present_slot #(
      .FLOOR_Y         (FLOOR_Y),
      .FALL_STEP       (FALL_STEP),
      .LIFETIME_FRAMES (LIFETIME_FRAMES)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .frame_start (startOfFrame),
      .load        (load_vec[g]),
      .load_x      (req_x),
      .load_y      (req_y),
      .load_type   (req_type),
      .hit         (pickup_hit[g]),
      .valid       (slot_valid[g]),
      .x           (sx[g]),
      .y           (sy[g]),
      .ptype       (st[g])
    );
    assign slot_x[g*X_BITS +: X_BITS] = sx[g];
    assign slot_y[g*Y_BITS +: Y_BITS] = sy[g];
    assign slot_type[g*2 +: 2]        = st[g];
  end

endmodule

// File: tb/tb_present_scheduler.sv
// Directed bench for present_scheduler; allocations and awards are checked by a queue-driven monitor.
module tb_present_scheduler;
  import present_pkg::*;

  localparam int NS = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sof = 1'b0;
  logic [1:0]     pop_req = '0;
  logic [10:0]    pop_x0 = '0, pop_x1 = '0, pop_y0 = '0, pop_y1 = '0;
  logic           rand_rise;
  logic [1:0]     rand_dout = '0;
  logic [NS-1:0]  pickup_hit = '0;
  logic [NS-1:0]  slot_valid;
  logic [NS*11-1:0] slot_x, slot_y;
  logic [NS*2-1:0]  slot_type;
  logic           award_valid;
  logic [1:0]     award_type;

  present_scheduler dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pop_req(pop_req),
    .pop_x0(pop_x0), .pop_x1(pop_x1), .pop_y0(pop_y0), .pop_y1(pop_y1),
    .rand_rise(rand_rise), .rand_dout(rand_dout), .pickup_hit(pickup_hit),
    .slot_valid(slot_valid), .slot_x(slot_x), .slot_y(slot_y), .slot_type(slot_type),
    .award_valid(award_valid), .award_type(award_type)
  );

  always #5 clk = ~clk;

  typedef struct { int slot; int x; int y; int t; } alloc_t;
  alloc_t alloc_q[$];
  int     award_q[$];
  int     checks = 0;
  int     errors = 0;
  int     rise_cnt = 0;
  logic   prev_rise = 1'b0;
  logic [NS-1:0] prev_valid = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_alloc(input int s, input int x, input int y, input int t);
    alloc_t e;
    e.slot = s; e.x = x; e.y = y; e.t = t;
    alloc_q.push_back(e);
  endtask

  // Monitor: rand_rise width, new slot contents and awards.
  initial forever begin
    alloc_t e;
    @(negedge clk);
    if (!reset) begin
      if (prev_rise) check("rise_width", int'(rand_rise), 0);
      if (rand_rise && !prev_rise) rise_cnt++;
      for (int i = 0; i < NS; i++) begin
        if (slot_valid[i] && !prev_valid[i]) begin
          if (alloc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_alloc: slot %0d got valid expected empty", i);
          end else begin
            e = alloc_q.pop_front();
            check("alloc_slot", i, e.slot);
            check("alloc_x", int'(slot_x[i*11 +: 11]), e.x);
            check("alloc_y", int'(slot_y[i*11 +: 11]), e.y);
            check("alloc_type", int'(slot_type[i*2 +: 2]), e.t);
          end
        end
      end
      if (award_valid) begin
        if (award_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_award: got type %0d expected no award", award_type);
        end else begin
          check("award_type", int'(award_type), award_q.pop_front());
        end
      end
    end
    prev_rise  = rand_rise;
    prev_valid = slot_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk); sof = 1'b1;
      @(negedge clk); sof = 1'b0;
    end
  endtask

  task automatic pop(input logic [1:0] m, input logic [10:0] x0, input logic [10:0] y0,
                     input logic [10:0] x1, input logic [10:0] y1);
    @(negedge clk);
    pop_req = m; pop_x0 = x0; pop_y0 = y0; pop_x1 = x1; pop_y1 = y1;
    @(negedge clk);
    pop_req = '0;
  endtask

  task automatic pickup(input logic [NS-1:0] m);
    @(negedge clk); pickup_hit = m;
    @(negedge clk); pickup_hit = '0;
  endtask

  // Pop on requester 0 and count clocks from the sampling edge until slot_valid[s].
  task automatic pop_latency(input int s, input int exp_n, input logic [10:0] x, input logic [10:0] y);
    int n;
    @(negedge clk);
    pop_req = 2'b01; pop_x0 = x; pop_y0 = y;
    @(posedge clk); #1 pop_req = '0;
    n = 0;
    while (!slot_valid[s] && n < 10) begin
      @(posedge clk); #1 n++;
    end
    check("pop_latency", n, exp_n);
  endtask

  initial begin
    int r;
    int n;
    tick(3);
    check("rst_valid", int'(slot_valid), 0);
    check("rst_rise", int'(rand_rise), 0);
    check("rst_award", int'(award_valid), 0);
    check("rst_x", int'(slot_x[10:0]), 0);
    check("rst_type", int'(slot_type), 0);
    #2 reset = 1'b0;

    // Tie right after reset: requester 0 first.
    r = rise_cnt; rand_dout = 2'd2;
    expect_alloc(0, 20, 440, 2); expect_alloc(1, 30, 440, 2);
    pop(2'b11, 11'd20, 11'd440, 11'd30, 11'd440);
    tick(10);
    check("tie_a_valid", int'(slot_valid), 4'b0011);
    check("tie_a_rises", rise_cnt - r, 2);
    frames(30);

    // Requester 1 won last, so requester 0 wins again.
    rand_dout = 2'd0;
    expect_alloc(2, 40, 440, 0); expect_alloc(3, 50, 440, 0);
    pop(2'b11, 11'd40, 11'd440, 11'd50, 11'd440);
    tick(10);
    check("tie_b_valid", int'(slot_valid), 4'b1111);
    frames(30);

    // All slots full: request runs but nothing is written and cooldown stays 0.
    r = rise_cnt; rand_dout = 2'd1;
    pop(2'b01, 11'd60, 11'd440, 11'd0, 11'd0);
    tick(8);
    check("full_rises", rise_cnt - r, 1);
    check("full_valid", int'(slot_valid), 4'b1111);
    check("full_x0", int'(slot_x[10:0]), 20);
    award_q.push_back(2);
    pickup(4'b0110);
    check("multi_hit_valid", int'(slot_valid), 4'b1001);
    expect_alloc(1, 60, 440, 1);
    pop(2'b01, 11'd60, 11'd440, 11'd0, 11'd0);
    tick(6);
    check("no_cool_valid", int'(slot_valid), 4'b1011);
    award_q.push_back(0);
    pickup(4'b1000);
    frames(30);

    // Requester 0 won last: requester 1 takes this tie.
    rand_dout = 2'd2;
    expect_alloc(2, 80, 440, 2); expect_alloc(3, 70, 440, 2);
    pop(2'b11, 11'd70, 11'd440, 11'd80, 11'd440);
    tick(10);
    check("tie_c_valid", int'(slot_valid), 4'b1111);

    // Cooldown active: pop ignored.
    r = rise_cnt;
    pop(2'b01, 11'd90, 11'd440, 11'd0, 11'd0);
    tick(8);
    check("cooldown_rises", rise_cnt - r, 0);
    award_q.push_back(2);
    pickup(4'b1111);
    check("clear_all_valid", int'(slot_valid), 0);
    frames(30);

    // Fall to the floor then expire.
    rand_dout = 2'd1;
    expect_alloc(0, 5, 436, 1);
    pop(2'b01, 11'd5, 11'd436, 11'd0, 11'd0);
    tick(6);
    frames(1); check("fall_y1", int'(slot_y[10:0]), 438);
    frames(1); check("fall_y2", int'(slot_y[10:0]), 440);
    frames(1); check("fall_y3", int'(slot_y[10:0]), 440);
    check("floor_valid", int'(slot_valid[0]), 1);
    frames(178); check("life_almost", int'(slot_valid[0]), 1);
    frames(1);   check("life_expired", int'(slot_valid[0]), 0);

    // Type 3 present.
    r = rise_cnt; rand_dout = 2'd3;
`ifdef PRESENT_BLANK_EN
    pop(2'b01, 11'd7, 11'd440, 11'd0, 11'd0);
    tick(6);
    check("blank_valid", int'(slot_valid[0]), 0);
`else
    expect_alloc(0, 7, 440, 3);
    pop(2'b01, 11'd7, 11'd440, 11'd0, 11'd0);
    tick(6);
    check("type3_valid", int'(slot_valid[0]), 1);
`endif
    check("type3_rises", rise_cnt - r, 1);
    frames(30);

    // Reset while in REQ.
    rand_dout = 2'd2;
    pop(2'b01, 11'd11, 11'd440, 11'd0, 11'd0);
    n = 0;
    while (!rand_rise && n < 10) begin
      @(negedge clk); n++;
    end
    check("req_reached", int'(rand_rise), 1);
    #1 reset = 1'b1;
    #1;
    check("arst_rise", int'(rand_rise), 0);
    check("arst_valid", int'(slot_valid), 0);
    tick(2);
    #2 reset = 1'b0;

    r = rise_cnt; rand_dout = 2'd1;
    expect_alloc(0, 100, 50, 1);
    pop_latency(0, 4, 11'd100, 11'd50);
    tick(4);
    check("single_rises", rise_cnt - r, 1);
    check("single_valid", int'(slot_valid), 4'b0001);

    check("alloc_q_empty", alloc_q.size(), 0);
    check("award_q_empty", award_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_scheduler.md
# present_scheduler

Controller that turns bubble-pop events into falling presents for the Bubble Trouble game. It arbitrates pop events from two shot requesters and sequences the free-running random present generator through a rise/sample handshake. It allocates each present into one of NUM_SLOTS slots, animates each present's fall once per frame, and retires it on pickup or on lifetime expiry. It sits between the shot/bubble collision logic and the present draw and pickup logic.

## Interface
- NUM_SLOTS, 4, concurrent present slots
- X_BITS, 11, x coordinate width
- Y_BITS, 11, y coordinate width
- FLOOR_Y, 440, resting y of a present
- FALL_STEP, 2, y pixels added per frame while falling
- LIFETIME_FRAMES, 180, frames a present stays on the floor
- COOLDOWN_FRAMES, 30, frames after a drop during which pops are ignored
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- pop_req  in  2  one-cycle pop pulse per requester (bit 0 = player 1 shot, bit 1 = player 2 shot)
- pop_x0, pop_x1  in  X_BITS  pop x per requester, valid with its pulse
- pop_y0, pop_y1  in  Y_BITS  pop y per requester, valid with its pulse
- rand_rise  out  1  drive to random generator rise input
- rand_dout  in  2  random generator output
- pickup_hit  in  NUM_SLOTS  player/present collision, one bit per slot
- slot_valid  out  NUM_SLOTS  slot occupied
- slot_x  out  NUM_SLOTS*X_BITS  packed x, slot 0 in the low bits
- slot_y  out  NUM_SLOTS*Y_BITS  packed y
- slot_type  out  NUM_SLOTS*2  packed present type
- award_valid  out  1  one-cycle pulse on pickup
- award_type  out  2  type of the picked present, valid with award_valid

## Operation
- Reset values: all outputs 0. FSM is IDLE, pending flags are cleared, cooldown is 0.
- Pending latch: a pop_req bit with cooldown==0 sets that requester's pending flag and captures its x/y. A pulse on an already-pending requester is lost. Pops while cooldown>0 are ignored.
- FSM IDLE: if any pending flag is set, grant it round-robin. The last-granted requester loses a tie, and after reset requester 0 has priority. Clear the granted flag and go to REQ.
- FSM REQ: rand_rise=1 for exactly one cycle, then go to WAIT.
- FSM WAIT: rand_rise=0, capture rand_dout, then go to ALLOC. rand_rise is therefore low for at least 2 cycles between pulses, so every request is a fresh rising edge for the generator.
- FSM ALLOC: write the lowest-index free slot with x=pop x, y=pop y, type=captured value, lifetime=LIFETIME_FRAMES. Load cooldown=COOLDOWN_FRAMES, then go to IDLE.
- ALLOC with no free slot: discard the request, leave cooldown unchanged, go to IDLE.
- Cooldown decrements on each startOfFrame and saturates at 0.
- Per slot, on startOfFrame:
  - If y<FLOOR_Y, set y=min(y+FALL_STEP, FLOOR_Y), with the sum computed at Y_BITS+1 bits.
  - Otherwise decrement lifetime. When it reaches 0, clear valid.
- Per slot, pickup_hit while valid clears valid, pulses award_valid, and sets award_type to the slot type. Multiple simultaneous hits award only the lowest index. The other hit slots are still cleared.
- pickup_hit on an invalid slot is ignored.
- Priority within one cycle: pickup, then lifetime expiry, then fall. ALLOC never targets a slot that was valid at the start of the cycle.
- Reset mid-operation clears everything immediately, including any in-flight grant. rand_rise drops asynchronously.

## Timing
- Pop pulse sampled at edge E0 → REQ from E1 → generator latches at E2 → ALLOC at E3 → slot_valid high after E4. Latency is 4 clocks when IDLE.
- Throughput: one allocation per 4 cycles.
- award_valid is asserted the cycle after pickup_hit. slot_valid drops on the same edge.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- PRESENT_BLANK_EN defined: type 3 (PT_NONE) means no drop. ALLOC writes no slot and does not load cooldown, so 25% of pops yield nothing.
- PRESENT_BLANK_EN undefined: all four types are dropped. Type 3 is a valid present.

## Structure
- present_pkg holds:
  - present_type_t enum: PT_LIFE=0, PT_TIME=1, PT_SHIELD=2, PT_NONE=3
  - sched_state_t enum: IDLE, REQ, WAIT, ALLOC
  - slot_t struct: valid, x, y, type, lifetime
- Sub-module present_slot: one slot's registers plus its fall, lifetime and pickup logic, instantiated NUM_SLOTS times. It takes a load strobe and load data from the scheduler.

## Test plan
- Single pop from requester 0 at (100,50) with rand_dout=1 → rand_rise pulse 1 cycle; slot 0 valid after 4 clocks with x=100, y=50, type=1.
- Simultaneous pops on both requesters with cooldown forced to 0 → requester 0 allocated first, requester 1 on the next ALLOC; next tie goes to requester 0 only after requester 1 wins.
- Slot at y=436 with FALL_STEP=2 → frames give 438, 440, 440; after LIFETIME_FRAMES more frames, slot_valid drops.
- All 4 slots full plus a pop → no change, cooldown unchanged; pickup_hit=4'b0110 → award_type of slot 1 only, slots 1 and 2 cleared.
- Pop during cooldown → no rand_rise. rand_dout=3 with PRESENT_BLANK_EN → no slot; without it → slot type 3.
- Reset asserted in the REQ state → rand_rise=0 and all slots cleared immediately; the first pop after release behaves as the single-pop case.
